// File: rtl/gol_pkg.sv
// Shared constants and helpers for the 8x8 Game of Life engine.
// Grid geometry, seed pattern and default colours.
package gol_pkg;

    localparam int GRID_DIM = 8;

    typedef logic [GRID_DIM-1:0] grid_t [GRID_DIM];

    localparam grid_t SEED = '{
        8'h00, 8'h00, 8'h12, 8'h08,
        8'h22, 8'h1E, 8'h00, 8'h00
    };

    localparam logic [23:0] LIVE_RGB_DEF = 24'h00FF00;
    localparam logic [23:0] DEAD_RGB_DEF = 24'h000000;

    // Toroidal index: -1 maps to 7, 8 maps to 0.
    function automatic int wrap_idx(input int idx);
        return (idx + GRID_DIM) % GRID_DIM;
    endfunction

endpackage

// File: rtl/gol_cell_next.sv
// B3/S23 next-state function for one cell.
// Counts the eight neighbours and applies birth/survival.
module gol_cell_next (
    input  logic [7:0] nbrs,
    input  logic       alive,
    output logic       next
);

    logic [3:0] count;

    always_comb begin
        count = '0;
        for (int i = 0; i < 8; i++) begin
            count = count + {3'b000, nbrs[i]};
        end
    end

    assign next = (count == 4'd3) || (alive && (count == 4'd2));

endmodule

// File: rtl/game_of_life.sv
// 8x8 toroidal Game of Life engine with registered colour lookup.
// Advances one generation when frame lands on a new multiple of FRAMES_PER_GEN.
module game_of_life
    import gol_pkg::*;
#(
    parameter int          FRAMES_PER_GEN = 16,
    parameter logic [23:0] LIVE_RGB       = LIVE_RGB_DEF,
    parameter logic [23:0] DEAD_RGB       = DEAD_RGB_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] pixel,
    input  logic [4:0] frame,
    output logic [7:0] red_data,
    output logic [7:0] green_data,
    output logic [7:0] blue_data
);

    localparam logic [4:0] FMASK = 5'(FRAMES_PER_GEN - 1);

    grid_t       current_grid;
    logic [4:0]  frame_q;
    logic        step;
    logic [63:0] next_flat;
    logic [23:0] rgb_q;
    logic        cell_sel;

    assign step = (frame != frame_q) && ((frame & FMASK) == 5'd0);

    for (genvar r = 0; r < GRID_DIM; r++) begin : g_row
        localparam int RU = wrap_idx(r - 1);
        localparam int RD = wrap_idx(r + 1);
        for (genvar c = 0; c < GRID_DIM; c++) begin : g_col
            localparam int CL = wrap_idx(c - 1);
            localparam int CR = wrap_idx(c + 1);
            gol_cell_next u_cell (
                .nbrs  ({current_grid[RU][CL], current_grid[RU][c],
                         current_grid[RU][CR], current_grid[r][CL],
                         current_grid[r][CR],  current_grid[RD][CL],
                         current_grid[RD][c],  current_grid[RD][CR]}),
                .alive (current_grid[r][c]),
                .next  (next_flat[r*GRID_DIM+c])
            );
        end
    end

    // Lookup uses the pre-update grid on a stepping edge.
    assign cell_sel = current_grid[pixel[5:3]][pixel[2:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            current_grid <= SEED;
            frame_q      <= '0;
            rgb_q        <= DEAD_RGB;
        end else begin
            frame_q <= frame;
            rgb_q   <= cell_sel ? LIVE_RGB : DEAD_RGB;
            if (step) begin
                for (int r = 0; r < GRID_DIM; r++) begin
                    current_grid[r] <= next_flat[r*GRID_DIM +: GRID_DIM];
                end
            end
        end
    end

    assign red_data   = rgb_q[23:16];
    assign green_data = rgb_q[15:8];
    assign blue_data  = rgb_q[7:0];

endmodule

// File: tb/tb_game_of_life.sv
// Self-checking bench for game_of_life against a torus B3/S23 model.
// Random pixel lookups and frame sequences drive the comparisons.
module tb_game_of_life;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] pixel;
    logic [4:0] frame;
    logic [7:0] red_data, green_data, blue_data;

    int n_cmp = 0;
    int n_err = 0;

    bit mdl [8][8];
    int prev_f;

    game_of_life dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pixel      (pixel),
        .frame      (frame),
        .red_data   (red_data),
        .green_data (green_data),
        .blue_data  (blue_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mrow(input int r);
        logic [7:0] v;
        for (int c = 0; c < 8; c++) v[c] = mdl[r][c];
        return v;
    endfunction

    task automatic model_seed();
        logic [63:0] s;
        s = {8'h00, 8'h00, 8'h1E, 8'h22, 8'h08, 8'h12, 8'h00, 8'h00};
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                mdl[r][c] = s[r*8+c];
    endtask

    task automatic model_step();
        bit nx [8][8];
        int n;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0)
                            n += int'(mdl[(r+dr+8)%8][(c+dc+8)%8]);
                nx[r][c] = (n == 3) || (mdl[r][c] && n == 2);
            end
        end
        mdl = nx;
    endtask

    task automatic load_grid(input logic [63:0] g);
        for (int r = 0; r < 8; r++) begin
            dut.current_grid[r] = g[r*8 +: 8];
            for (int c = 0; c < 8; c++) mdl[r][c] = g[r*8+c];
        end
    endtask

    task automatic cmp_grid(input string tag);
        for (int r = 0; r < 8; r++)
            chk($sformatf("%s_row%0d", tag, r), 32'(dut.current_grid[r]),
                32'(mrow(r)));
    endtask

    // Drive one cycle; model decides the step from the trigger rule.
    task automatic tick_p(input int f, input logic [5:0] p);
        logic [23:0] exp;
        frame = 5'(f);
        pixel = p;
        exp = mdl[p[5:3]][p[2:0]] ? 24'h00FF00 : 24'h000000;
        if (f != prev_f && (f % 16) == 0) model_step();
        prev_f = f;
        @(negedge clk);
        chk("rgb", 32'({red_data, green_data, blue_data}), 32'(exp));
    endtask

    task automatic tick(input int f);
        tick_p(f, 6'($urandom));
    endtask

    logic [7:0] last_row3;
    int         changes;
    int         f;

    initial begin
        rst_n  = 1'b0;
        frame  = '0;
        pixel  = '0;
        prev_f = 0;
        model_seed();
        repeat (3) @(negedge clk);
        chk("rst_rgb", 32'({red_data, green_data, blue_data}), 32'h0);
        rst_n = 1'b1;
        cmp_grid("seed");

        tick_p(0, 6'o21);
        chk("o21_green", 32'(green_data), 32'hFF);
        tick_p(0, 6'o20);
        repeat (10) tick(0);

        // Blinker, then wrap 31 -> 0
        load_grid(64'h0000_0000_1C00_0000);
        tick(16);
        cmp_grid("blink1");
        chk("blink1_r3", 32'(dut.current_grid[3]), 32'h08);
        tick(31);
        tick(0);
        cmp_grid("blink2");
        chk("blink2_r3", 32'(dut.current_grid[3]), 32'h1C);

        // Block still life over 5 generations
        load_grid(64'h0000_0000_0006_0600);
        for (int g = 0; g < 5; g++) tick((g % 2 == 0) ? 16 : 0);
        cmp_grid("block");
        chk("block_r1", 32'(dut.current_grid[1]), 32'h06);

        // Vertical triple wrapping through rows 7/0/1 at column 7
        tick(1);
        load_grid(64'h8000_0000_0000_8080);
        tick(16);
        cmp_grid("torus");
        chk("torus_r7", 32'(dut.current_grid[7]), 32'h00);
        chk("torus_r1", 32'(dut.current_grid[1]), 32'h00);

        // Frame held at 16 for 40 cycles: one generation only
        tick(0);
        load_grid(64'h0000_0000_1C00_0000);
        last_row3 = dut.current_grid[3];
        changes = 0;
        for (int i = 0; i < 40; i++) begin
            tick(16);
            if (dut.current_grid[3] != last_row3) changes++;
            last_row3 = dut.current_grid[3];
        end
        chk("hold_steps", 32'(changes), 32'd1);
        cmp_grid("hold");

        // Increment by one per cycle: steps only at 16 and 0
        tick(0);
        load_grid(64'h0000_0000_1C00_0000);
        last_row3 = dut.current_grid[3];
        changes = 0;
        for (int i = 1; i <= 32; i++) begin
            tick(i % 32);
            if (dut.current_grid[3] != last_row3) changes++;
            last_row3 = dut.current_grid[3];
            chk($sformatf("inc%0d_r3", i), 32'(dut.current_grid[3]),
                32'(mrow(3)));
        end
        chk("inc_steps", 32'(changes), 32'd2);

        // Random grid, random frame jumps
        tick(3);
        load_grid({$urandom, $urandom});
        for (int i = 0; i < 30; i++) tick(int'($urandom_range(0, 31)));
        cmp_grid("rand");

        // Seed run with async reset pulse mid-run
        rst_n = 1'b0;
        #1;
        rst_n  = 1'b1;
        frame  = '0;
        prev_f = 0;
        model_seed();
        @(negedge clk);
        f = 0;
        for (int g = 1; g <= 5; g++) begin
            for (int k = 0; k < 17; k++) begin
                f = (f + 1) % 32;
                tick(f);
            end
            cmp_grid($sformatf("gen%0d", g));
            if (g == 3) begin
                #2;
                rst_n = 1'b0;
                #1;
                chk("arst_r2", 32'(dut.current_grid[2]), 32'h12);
                chk("arst_r5", 32'(dut.current_grid[5]), 32'h1E);
                chk("arst_rgb", 32'({red_data, green_data, blue_data}),
                    32'h0);
                @(negedge clk);
                rst_n  = 1'b1;
                prev_f = 0;
                model_seed();
                cmp_grid("arst");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
